instr_issuer: RTL and testbench
===============================

Name: instr_issuer

Overview:
Host-side initiator for the cpu's load/s/w command interface. It holds a small program buffer and issues each instruction to the cpu: it presents the word with load, pulses s, then waits for w to fall and rise again. After each completion it captures the cpu result and N/V/Z flags. It sits between a host or test driver and the cpu top level, replacing manual switch/key stimulus.

Parameters:
DEPTH, 16, number of 16-bit program entries
AW, 4, address width, log2(DEPTH)
TIMEOUT, 32, maximum cycles allowed from s deassertion to w rising before the run aborts

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
prog_we  in  1  program buffer write strobe (ignored while busy)
prog_addr  in  AW  write address
prog_data  in  16  instruction word
run  in  1  start request, sampled in IDLE only
start_addr  in  AW  first entry to issue
count  in  AW+1  number of entries to issue, 0..DEPTH
cpu_in  out  16  instruction to cpu
cpu_load  out  1  instruction register load strobe
cpu_s  out  1  cpu start strobe
cpu_w  in  1  cpu waiting (1 = idle/complete)
cpu_out  in  16  cpu datapath output
cpu_N, cpu_V, cpu_Z  in  1 each  cpu status flags
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run (normal, halt or error)
err  out  1  timeout occurred; sticky until the next accepted run
issued  out  AW+1  instructions completed in the current or last run
last_result  out  16  cpu_out captured at the last completion
last_flags  out  3  {N,V,Z} captured at the last completion

Behaviour:
- All outputs are registered. Reset low at an edge returns every output to 0 and the state to IDLE. Reset takes priority in any state, including mid-handshake; the buffer contents are not cleared.
- States: IDLE, FETCH, LOAD, START, WAIT_BUSY, WAIT_DONE, FINISH.
- IDLE: run=1 → FETCH. Latch addr=start_addr and remaining=count. Clear issued and err. Set busy=1.
- FETCH: one cycle, no cpu strobes. Go to FINISH if remaining==0 or mem[addr][15:13]==3'b111 (halt; the word is not issued). Otherwise go to LOAD.
- LOAD: cpu_in=mem[addr], cpu_load=1 for exactly one cycle.
- START: cpu_s=1 for exactly one cycle. cpu_in is held.
- WAIT_BUSY: wait for cpu_w==0, then go to WAIT_DONE.
- WAIT_DONE: wait for cpu_w==1. On that cycle capture last_result=cpu_out and last_flags={N,V,Z}, increment issued, set addr=addr+1 (wraps DEPTH-1→0), decrement remaining, and go to FETCH.
- Timeout: a counter clears on entering WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE. Reaching TIMEOUT → FINISH with err=1. issued is not incremented and nothing is captured.
- FINISH: done=1 for one cycle, busy=0 on exit → IDLE. cpu_in holds its last value.
- cpu_load and cpu_s are never high in the same cycle and are never high outside LOAD/START.
- run while busy: ignored. prog_we while busy: ignored. prog_we and run in the same IDLE cycle: the write completes, and the run uses the updated buffer only if FETCH follows, which it does.
- Latency per instruction is 4 cycles plus cpu execution time. A run with count=0 produces done 2 cycles after run is sampled.

Decomposition:
- Shared package holds:
  - opcode constants: MOV=3'b110, ALU=3'b101, HALT=3'b111
  - state encoding (3-bit)
  - flag bit indices N=2, V=1, Z=0
- One sub-module, issue_prog_mem: DEPTH×16 register array, single synchronous write, asynchronous read.

Test Plan:
- Run a behavioural cpu model. Load mem[0..2] = 16'hD007 (MOV R0,#7), 16'hD102 (MOV R1,#2), 16'hA140 (ADD R2,R1,R0). Set start_addr=0, count=3, pulse run. Required: exactly three cpu_load pulses carrying D007, D102, A140 in order, each followed one cycle later by cpu_s; done pulse; issued=3; last_result=16'd9; err=0.
- count=0 with run → no cpu_load or cpu_s; done two cycles after run is sampled; issued=0.
- mem[0]=D007, mem[1]=16'hE000, count=4 → one instruction issued; done; issued=1; err=0; cpu_load is never asserted with E000.
- cpu_w held at 1 permanently, TIMEOUT=32, count=2 → one load/s pair; err=1 and done 32 cycles after cpu_s falls; issued=0; no further strobes.
- start_addr=15, count=2, DEPTH=16 → issued words are mem[15] then mem[0]; issued=2.
- Assert reset low during WAIT_DONE → busy, cpu_load, cpu_s, done, err and issued are all 0 the next cycle. A run pulsed while busy (before the reset) is ignored; a run after reset starts cleanly.

Source files
------------

// File: rtl/instr_issuer_pkg.sv
// Shared constants and state encoding for the instruction issuer.
package instr_issuer_pkg;

    // Opcode field [15:13] of a cpu instruction word
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Bit positions inside the {N,V,Z} flag vector
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LOAD      = 3'd2,
        S_START     = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_FINISH    = 3'd6
    } issue_state_t;

    // A halt word terminates the run without being sent to the cpu
    function automatic logic is_halt(input logic [15:0] word);
        return word[15:13] == OP_HALT;
    endfunction

endpackage

// File: rtl/issue_prog_mem.sv
// Program buffer: DEPTH x 16 register array, one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module issue_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Single write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Host-side initiator that walks the program buffer and issues each word
// to the cpu, capturing the cpu result and flags after every completion.
//
// cpu handshake: cpu_in is valid while cpu_load is high (one cycle), then
// cpu_s pulses for one cycle with cpu_in held. The cpu acknowledges by
// dropping cpu_w and signals completion by raising it again; the issuer
// samples cpu_out/flags in the cycle it first sees cpu_w high again.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          run,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   count,
    output logic [15:0]   cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    input  logic          cpu_w,
    input  logic [15:0]   cpu_out,
    input  logic          cpu_N,
    input  logic          cpu_V,
    input  logic          cpu_Z,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   issued,
    output logic [15:0]   last_result,
    output logic [2:0]    last_flags
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    issue_state_t  state, state_n;
    logic [AW-1:0] addr, addr_n;
    logic [AW:0]   remaining, remaining_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [15:0]   cpu_in_n, last_result_n;
    logic [2:0]    last_flags_n, flags_now;
    logic [AW:0]   issued_n;
    logic          err_n;
    logic          mem_we;
    logic [15:0]   word;

    // Host writes land only while idle so a running program is never altered
    assign mem_we = prog_we && (state == S_IDLE);

    issue_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (addr),
        .rdata (word)
    );

    // Pack the cpu status bits into the {N,V,Z} layout
    always_comb begin
        flags_now         = '0;
        flags_now[FLAG_N] = cpu_N;
        flags_now[FLAG_V] = cpu_V;
        flags_now[FLAG_Z] = cpu_Z;
    end

    // Next-state logic and next values of every registered output
    always_comb begin
        state_n       = state;
        addr_n        = addr;
        remaining_n   = remaining;
        tmo_n         = tmo;
        cpu_in_n      = cpu_in;
        last_result_n = last_result;
        last_flags_n  = last_flags;
        issued_n      = issued;
        err_n         = err;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_n     = S_FETCH;
                    addr_n      = start_addr;
                    remaining_n = count;
                    issued_n    = '0;
                    err_n       = 1'b0;
                end
            end
            S_FETCH: begin
                if (remaining == '0 || is_halt(word)) begin
                    state_n = S_FINISH;
                end else begin
                    state_n  = S_LOAD;
                    cpu_in_n = word;
                end
            end
            S_LOAD:  state_n = S_START;
            S_START: begin
                state_n = S_WAIT_BUSY;
                tmo_n   = '0;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
                tmo_n = tmo + 1'b1;
                // A completion seen on the final allowed cycle still counts
                if (state == S_WAIT_DONE && cpu_w) begin
                    state_n       = S_FETCH;
                    last_result_n = cpu_out;
                    last_flags_n  = flags_now;
                    issued_n      = issued + 1'b1;
                    addr_n        = addr + 1'b1;
                    remaining_n   = remaining - 1'b1;
                end else if (tmo == TMO_LAST) begin
                    state_n = S_FINISH;
                    err_n   = 1'b1;
                end else if (state == S_WAIT_BUSY && !cpu_w) begin
                    state_n = S_WAIT_DONE;
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // State and output registers; strobes are decoded from the next state
    // so they line up exactly with the LOAD/START/FINISH cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            tmo         <= '0;
            cpu_in      <= '0;
            cpu_load    <= 1'b0;
            cpu_s       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            issued      <= '0;
            last_result <= '0;
            last_flags  <= '0;
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            remaining   <= remaining_n;
            tmo         <= tmo_n;
            cpu_in      <= cpu_in_n;
            cpu_load    <= (state_n == S_LOAD);
            cpu_s       <= (state_n == S_START);
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_FINISH);
            err         <= err_n;
            issued      <= issued_n;
            last_result <= last_result_n;
            last_flags  <= last_flags_n;
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: a behavioural cpu answers the load/s/w handshake,
// a reference model predicts issued words and end-of-run results, and a
// monitor compares them against what the issuer presents.
module tb_instr_issuer;
    import instr_issuer_pkg::*;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          run;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic [15:0]   cpu_in;
    logic          cpu_load, cpu_s;
    logic          cpu_w;
    logic [15:0]   cpu_out;
    logic          cpu_N, cpu_V, cpu_Z;
    logic          busy, done, err;
    logic [AW:0]   issued;
    logic [15:0]   last_result;
    logic [2:0]    last_flags;

    instr_issuer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .run(run), .start_addr(start_addr), .count(count),
        .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_w(cpu_w),
        .cpu_out(cpu_out), .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
        .busy(busy), .done(done), .err(err), .issued(issued),
        .last_result(last_result), .last_flags(last_flags)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          load_cnt = 0;
    int          s_cnt    = 0;
    int          cpu_mode = 0;   // 0 normal, 1 never answers, 2 drops w and hangs
    logic [15:0] exp_q[$];       // words expected on cpu_in at each cpu_load
    logic [24:0] end_q[$];       // {err, issued[4:0], flags[2:0], result[15:0]} per done
    logic [15:0] mem_m [DEPTH];
    logic [15:0] shadow_r [8];
    logic [15:0] cpu_r [8];
    logic [15:0] last_res_m = '0;
    logic [2:0]  last_flags_m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- ISA semantics used by cpu and reference ----------------
    // Returns {N,V,Z,result} for a word given R[Rn]=a and R[Rm]=b
    function automatic logic [18:0] isa_eval(input logic [15:0] w, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0] r;
        logic        v;
        logic [2:0]  f;
        r = '0;
        v = 1'b0;
        if (w[15:13] == OP_MOV) begin
            r = w[12] ? {{8{w[7]}}, w[7:0]} : b;
        end else if (w[15:13] == OP_ALU) begin
            case (w[12:11])
                2'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
                2'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
                2'd2: r = a & b;
                default: r = ~b;
            endcase
        end
        f = '0;
        f[FLAG_N] = r[15];
        f[FLAG_V] = v;
        f[FLAG_Z] = (r == 16'd0);
        return {f, r};
    endfunction

    // Returns {write_enable, destination register}
    function automatic logic [3:0] isa_dest(input logic [15:0] w);
        if (w[15:13] == OP_MOV) return w[12] ? {1'b1, w[10:8]} : {1'b1, w[7:5]};
        if (w[15:13] == OP_ALU) return (w[12:11] == 2'd1) ? 4'd0 : {1'b1, w[7:5]};
        return 4'd0;
    endfunction

    function automatic logic [15:0] rand_word();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return {OP_HALT, 13'($urandom)};
        if (k <= 3) return {OP_MOV, 2'b10, 3'($urandom), 8'($urandom)};
        if (k == 4) return {OP_MOV, 2'b00, 11'($urandom)};
        return {OP_ALU, 13'($urandom)};
    endfunction

    // ---------------- behavioural cpu ----------------
    initial begin : cpu_model
        int          phase;
        int          cnt;
        logic [15:0] ir;
        logic [18:0] fr;
        logic [3:0]  dst;
        phase = 0; cnt = 0; ir = '0;
        cpu_w = 1'b1; cpu_out = '0; cpu_N = 1'b0; cpu_V = 1'b0; cpu_Z = 1'b0;
        for (int i = 0; i < 8; i++) cpu_r[i] = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                phase = 0;
                cpu_w = 1'b1;
                for (int i = 0; i < 8; i++) cpu_r[i] = '0;
            end else begin
                if (cpu_load) ir = cpu_in;
                case (phase)
                    0: if (cpu_s && cpu_mode != 1) begin
                        phase = 1;
                        cnt = $urandom_range(0, 2);
                    end
                    1: if (cnt == 0) begin
                        cpu_w = 1'b0;
                        phase = 2;
                        cnt = $urandom_range(0, 4);
                    end else cnt--;
                    default: if (cpu_mode != 2) begin
                        if (cnt == 0) begin
                            fr  = isa_eval(ir, cpu_r[ir[10:8]], cpu_r[ir[2:0]]);
                            dst = isa_dest(ir);
                            if (dst[3]) cpu_r[dst[2:0]] = fr[15:0];
                            cpu_out = fr[15:0];
                            cpu_N = fr[16 + FLAG_N];
                            cpu_V = fr[16 + FLAG_V];
                            cpu_Z = fr[16 + FLAG_Z];
                            cpu_w = 1'b1;
                            phase = 0;
                        end else cnt--;
                    end
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        prev_load;
        logic [15:0] prev_in;
        logic [24:0] rec;
        prev_load = 1'b0;
        prev_in   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("load_s_exclusive", 32'(cpu_load & cpu_s), 32'd0);
                if (prev_load) begin
                    chk("s_after_load", 32'(cpu_s), 32'd1);
                    chk("cpu_in_held", 32'(cpu_in), 32'(prev_in));
                end
                if (cpu_load) begin
                    load_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_load: got %h expected no load", cpu_in);
                    end else begin
                        chk("load_word", 32'(cpu_in), 32'(exp_q.pop_front()));
                    end
                end
                if (cpu_s) s_cnt++;
                if (done) begin
                    if (end_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_done: got done=1 expected 0");
                    end else begin
                        rec = end_q.pop_front();
                        chk("end_err", 32'(err), 32'(rec[24]));
                        chk("end_issued", 32'(issued), 32'(rec[23:19]));
                        chk("end_flags", 32'(last_flags), 32'(rec[18:16]));
                        chk("end_result", 32'(last_result), 32'(rec[15:0]));
                    end
                end
            end
            prev_load = cpu_load & reset;
            prev_in   = cpu_in;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_raw(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [15:0] d);
        mem_m[a] = d;
        write_raw(a, d);
    endtask

    // Predicts the run from the buffer image, then pulses run for one cycle
    task automatic start_run(input logic [3:0] sa, input int cnt, input bit tmo_expect,
                             input bit expect_end);
        logic [3:0]  a;
        int          rem, n;
        logic [18:0] fr;
        logic [3:0]  dst;
        a = sa; rem = cnt; n = 0;
        if (tmo_expect) begin
            exp_q.push_back(mem_m[a]);
        end else begin
            while (rem > 0 && mem_m[a][15:13] != OP_HALT) begin
                exp_q.push_back(mem_m[a]);
                fr  = isa_eval(mem_m[a], shadow_r[mem_m[a][10:8]], shadow_r[mem_m[a][2:0]]);
                dst = isa_dest(mem_m[a]);
                if (dst[3]) shadow_r[dst[2:0]] = fr[15:0];
                last_res_m   = fr[15:0];
                last_flags_m = fr[18:16];
                n++;
                a = a + 4'd1;
                rem--;
            end
        end
        if (expect_end) end_q.push_back({tmo_expect, 5'(n), last_flags_m, last_res_m});
        @(negedge clk);
        run = 1'b1; start_addr = sa; count = 5'(cnt);
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) shadow_r[i] = '0;
        last_res_m   = '0;
        last_flags_m = '0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int l0, s0, c;
        reset = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start_addr = '0; count = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_issued", 32'(issued), 32'd0);
        chk("rst_load", 32'(cpu_load), 32'd0);
        chk("rst_s", 32'(cpu_s), 32'd0);
        chk("rst_cpu_in", 32'(cpu_in), 32'd0);
        chk("rst_result", 32'(last_result), 32'd0);
        reset = 1'b1;

        // Three-instruction program; a write attempted mid-run must be ignored
        write_mem(4'd0, 16'hD007);
        write_mem(4'd1, 16'hD102);
        write_mem(4'd2, 16'hA140);
        l0 = load_cnt;
        start_run(4'd0, 3, 1'b0, 1'b1);
        write_raw(4'd2, 16'hD0AA);
        wait_done(300);
        chk("prog_loads", 32'(load_cnt - l0), 32'd3);
        chk("prog_result", 32'(last_result), 32'd9);
        chk("prog_issued", 32'(issued), 32'd3);
        chk("prog_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);

        // count = 0: done in the second cycle after run is sampled
        l0 = load_cnt; s0 = s_cnt;
        start_run(4'd0, 0, 1'b0, 1'b1);
        chk("cnt0_busy", 32'(busy), 32'd1);
        chk("cnt0_early_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("cnt0_done", 32'(done), 32'd1);
        chk("cnt0_issued", 32'(issued), 32'd0);
        @(negedge clk);
        chk("cnt0_loads", 32'(load_cnt - l0), 32'd0);
        chk("cnt0_starts", 32'(s_cnt - s0), 32'd0);

        // Halt word stops the run before being issued
        write_mem(4'd1, 16'hE000);
        l0 = load_cnt;
        start_run(4'd0, 4, 1'b0, 1'b1);
        wait_done(300);
        chk("halt_loads", 32'(load_cnt - l0), 32'd1);
        chk("halt_issued", 32'(issued), 32'd1);

        // cpu never answers: timeout 32 cycles after cpu_s falls
        write_mem(4'd1, 16'hD102);
        cpu_mode = 1;
        l0 = load_cnt;
        start_run(4'd0, 2, 1'b1, 1'b1);
        c = 0;
        while (cpu_s !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        chk("tmo_s_seen", 32'(cpu_s), 32'd1);
        @(negedge clk);
        chk("tmo_s_one_cycle", 32'(cpu_s), 32'd0);
        c = 0;
        while (done !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        chk("tmo_latency", 32'(c), 32'(TIMEOUT));
        chk("tmo_err", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        chk("tmo_err_sticky", 32'(err), 32'd1);
        chk("tmo_loads", 32'(load_cnt - l0), 32'd1);
        cpu_mode = 0;

        // Address wraps from DEPTH-1 to 0
        write_mem(4'd15, 16'hD105);
        start_run(4'd15, 2, 1'b0, 1'b1);
        wait_done(300);
        chk("wrap_issued", 32'(issued), 32'd2);
        chk("wrap_err_cleared", 32'(err), 32'd0);

        // Reset in WAIT_DONE, with an ignored run pulsed while busy
        cpu_mode = 2;
        start_run(4'd0, 1, 1'b0, 1'b0);
        c = 0;
        while (cpu_w !== 1'b0 && c < 20) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        chk("rstmid_busy_before", 32'(busy), 32'd1);
        run = 1'b1; start_addr = 4'd5; count = 5'd3;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_load", 32'(cpu_load), 32'd0);
        chk("rstmid_s", 32'(cpu_s), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_err", 32'(err), 32'd0);
        chk("rstmid_issued", 32'(issued), 32'd0);
        chk("rstmid_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cpu_mode = 0;
        model_reset();
        write_mem(4'd0, 16'hD007);
        write_mem(4'd1, 16'hD102);
        write_mem(4'd2, 16'hA140);
        start_run(4'd0, 3, 1'b0, 1'b1);
        wait_done(300);
        chk("post_rst_result", 32'(last_result), 32'd9);

        // Randomized programs and runs
        for (int i = 0; i < DEPTH; i++) write_mem(4'(i), rand_word());
        for (int it = 0; it < 30; it++) begin
            for (int j = 0; j < 3; j++) write_mem(4'($urandom), rand_word());
            start_run(4'($urandom), $urandom_range(0, DEPTH), 1'b0, 1'b1);
            wait_done(1000);
            @(negedge clk);
            chk("rand_idle", 32'(busy), 32'd0);
        end

        repeat (5) @(negedge clk);
        chk("final_loads_drained", 32'(exp_q.size()), 32'd0);
        chk("final_ends_drained", 32'(end_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
